sprite_anim_ctrl: RTL and testbench
===================================

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 SHALL have parameter ATT_START_FR, default 6, attack-start duration in frames.
REQ-002 SHALL have parameter ATT_END_FR, default 4, attack-end (hitbox-active) duration in frames.
REQ-003 SHALL have parameter ATT_PULL_FR, default 6, attack-pull duration in frames.
REQ-004 SHALL have parameter HIT_FR, default 12, got-hit stun duration in frames.
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port facing  input  1  0 = faces right (player G), 1 = faces left (player R).
REQ-009 SHALL have ports btn_left, btn_right, btn_attack, btn_dir, btn_block  input  1 each  level inputs from the player's controls.
REQ-010 SHALL have port hit_in  input  1  pulse, any cycle, from collision logic: opponent hitbox touched this player.
REQ-011 SHALL have port state  output  4  animation state, encoding 0 idle, 1 walk, 2 walkback, 3 attstart, 4 attend, 5 attpull, 6 dirattstart, 7 dirattend, 8 dirattpull, 9 gothit, 10 block; drives the sprite ROM state select.
REQ-012 SHALL have port hitbox_active  output  1  high while state is 4 or 7.
REQ-013 SHALL have ports step_fwd, step_back  output  1 each  one-cycle movement request pulses.
REQ-014 SHALL have port busy  output  1  high in states 3-9 (non-interruptible by player input).

Function
REQ-015 SHALL evaluate transitions only in the cycle frame_tick=1; state is stable otherwise.
REQ-016 SHALL latch hit_in into hit_pend on any cycle; hit_pend clears in the tick cycle that consumes it.
REQ-017 Priority at a tick: hit_pend > running timed sequence > btn_attack > btn_dir > btn_block > walk > idle.
REQ-018 hit_pend at tick while state = 10: SHALL stay in block (hit absorbed), clear hit_pend.
REQ-019 hit_pend at tick in any other state (including 3-8, 9): SHALL enter 9 with frame counter reloaded to HIT_FR; a hit during 9 restarts the stun.
REQ-020 Timed states SHALL hold exactly their parameter count of ticks: 3->4->5->0 and 6->7->8->0, 9->0; counter reloads on every entry.
REQ-021 On leaving a timed sequence into 0, inputs SHALL not be re-evaluated until the next tick (one idle frame minimum).
REQ-022 Forward = btn_right when facing=0, btn_left when facing=1; back is the opposite; both pressed or neither -> idle.
REQ-023 In state 1 or 2, SHALL pulse step_fwd/step_back for one cycle on each tick the state persists or is entered.
REQ-024 State 10 SHALL persist while btn_block=1 at each tick; release returns to 0 (or walk per REQ-022).
REQ-025 Frame counter SHALL be 5 bits, counting down to 1; parameters above 31 are illegal.
REQ-026 Outputs state, hitbox_active, busy SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst SHALL force state=0, counter=0, hit_pend=0, hitbox_active=0, busy=0, step_fwd=0, step_back=0 immediately.
REQ-028 rst asserted mid-sequence SHALL abort it; after release the first tick evaluates from idle.

Structure
REQ-029 State encoding constants (0-10) SHALL live in the shared game package, also used by the sprite ROM select and collision logic.
REQ-030 Frame countdown SHALL be a sub-module frame_timer (load, tick, value in, done out).
REQ-031 The game top SHALL instantiate one sprite_anim_ctrl per player (facing 0 and 1).

Verification
REQ-032 btn_attack held one tick from idle -> state 3 for 6 ticks, 4 for 4 ticks (hitbox_active=1), 5 for 6 ticks, then 0.
REQ-033 hit_in pulse between ticks during state 4 -> next tick state 9, hitbox_active=0, 12 ticks later state 0.
REQ-034 btn_block held, hit_in pulse -> state remains 10, hit_pend cleared, no entry to 9.
REQ-035 facing=1, btn_left held 3 ticks -> state 1, exactly 3 step_fwd pulses, 0 step_back; btn_left+btn_right -> state 0.
REQ-036 btn_attack and btn_dir both at tick -> state 3 (attack wins); btn_dir alone -> 6,7,8 sequence.
REQ-037 rst asserted during state 7 -> outputs zero asynchronously; after release no ticks -> state stays 0.

Source files
------------

// File: rtl/sprite_anim_ctrl_pkg.sv
// Shared game definitions: animation state encoding used by the animation
// controller, the sprite ROM state select and the collision logic.
package sprite_anim_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_WALK        = 4'd1,
      ST_WALKBACK    = 4'd2,
      ST_ATTSTART    = 4'd3,
      ST_ATTEND      = 4'd4,
      ST_ATTPULL     = 4'd5,
      ST_DIRATTSTART = 4'd6,
      ST_DIRATTEND   = 4'd7,
      ST_DIRATTPULL  = 4'd8,
      ST_GOTHIT      = 4'd9,
      ST_BLOCK       = 4'd10
   } anim_state_e;

   localparam int unsigned FRAME_CNT_W = 5;
   typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

   // Timed states run a frame countdown and ignore player input
   function automatic logic is_timed(input anim_state_e s);
      return (s >= ST_ATTSTART) && (s <= ST_GOTHIT);
   endfunction

   function automatic logic is_hitbox(input anim_state_e s);
      return (s == ST_ATTEND) || (s == ST_DIRATTEND);
   endfunction

endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// Player control / animation status bundle between the game logic (master)
// and one per-player animation controller (slave).
interface sprite_anim_ctrl_if;

   logic       frame_tick;
   logic       facing;
   logic       btn_left;
   logic       btn_right;
   logic       btn_attack;
   logic       btn_dir;
   logic       btn_block;
   logic       hit_in;
   logic [3:0] state;
   logic       hitbox_active;
   logic       step_fwd;
   logic       step_back;
   logic       busy;

   modport master (
      output frame_tick, facing, btn_left, btn_right, btn_attack, btn_dir, btn_block, hit_in,
      input  state, hitbox_active, step_fwd, step_back, busy
   );

   modport slave (
      input  frame_tick, facing, btn_left, btn_right, btn_attack, btn_dir, btn_block, hit_in,
      output state, hitbox_active, step_fwd, step_back, busy
   );

endinterface

// File: rtl/sprite_anim_ctrl_frame_timer.sv
// Frame countdown for timed animation states: load a duration, count down
// one per frame tick, done while the last frame of the state is showing.
module frame_timer
   import sprite_anim_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       tick,
   input  frame_cnt_t value,
   output logic       done
);

   frame_cnt_t count_r;

   // Countdown register; load wins over the tick decrement and it stops at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 5'd0;
      end else if (load) begin
         count_r <= value;
      end else if (tick && (count_r != 5'd0)) begin
         count_r <= count_r - 5'd1;
      end
   end

   assign done = (count_r == 5'd1);

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-player sprite animation state machine: turns controls and hit events
// into a frame-paced animation state, hitbox enable and movement pulses.
module sprite_anim_ctrl
   import sprite_anim_ctrl_pkg::*;
#(
   parameter int unsigned ATT_START_FR = 6,
   parameter int unsigned ATT_END_FR   = 4,
   parameter int unsigned ATT_PULL_FR  = 6,
   parameter int unsigned HIT_FR       = 12
)
(
   input  logic              clk,
   input  logic              rst,
   sprite_anim_ctrl_if.slave bus
);

   anim_state_e state_r;
   anim_state_e state_nxt_s;
   logic        hit_pend_r;
   logic        hitbox_r;
   logic        busy_r;
   logic        step_fwd_r;
   logic        step_back_r;
   logic        fwd_s;
   logic        back_s;
   logic        hold_s;
   logic        timer_load_s;
   logic        timer_done_s;
   frame_cnt_t  timer_val_s;

   function automatic frame_cnt_t duration(input anim_state_e s);
      case (s)
         ST_ATTSTART, ST_DIRATTSTART: return frame_cnt_t'(ATT_START_FR);
         ST_ATTEND,   ST_DIRATTEND:   return frame_cnt_t'(ATT_END_FR);
         ST_ATTPULL,  ST_DIRATTPULL:  return frame_cnt_t'(ATT_PULL_FR);
         ST_GOTHIT:                   return frame_cnt_t'(HIT_FR);
         default:                     return 5'd0;
      endcase
   endfunction

   // Forward/back follow the facing direction of the player
   assign fwd_s  = bus.facing ? bus.btn_left  : bus.btn_right;
   assign back_s = bus.facing ? bus.btn_right : bus.btn_left;

   // Next state at a frame tick; hold_s marks a timed state still counting
   always_comb begin
      state_nxt_s = state_r;
      hold_s      = 1'b0;
      if (bus.frame_tick) begin
         if (hit_pend_r) begin
            if (state_r == ST_BLOCK) begin
               state_nxt_s = ST_BLOCK;
            end else begin
               state_nxt_s = ST_GOTHIT;
            end
         end else if (is_timed(state_r)) begin
            if (timer_done_s) begin
               case (state_r)
                  ST_ATTSTART:    state_nxt_s = ST_ATTEND;
                  ST_ATTEND:      state_nxt_s = ST_ATTPULL;
                  ST_DIRATTSTART: state_nxt_s = ST_DIRATTEND;
                  ST_DIRATTEND:   state_nxt_s = ST_DIRATTPULL;
                  default:        state_nxt_s = ST_IDLE;
               endcase
            end else begin
               hold_s = 1'b1;
            end
         end else if (bus.btn_attack) begin
            state_nxt_s = ST_ATTSTART;
         end else if (bus.btn_dir) begin
            state_nxt_s = ST_DIRATTSTART;
         end else if (bus.btn_block) begin
            state_nxt_s = ST_BLOCK;
         end else if (fwd_s && !back_s) begin
            state_nxt_s = ST_WALK;
         end else if (back_s && !fwd_s) begin
            state_nxt_s = ST_WALKBACK;
         end else begin
            state_nxt_s = ST_IDLE;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Every tick that does not merely count down reloads the timer for the new state
   assign timer_load_s = bus.frame_tick & ~hold_s;
   assign timer_val_s  = duration(state_nxt_s);

   frame_timer u_frame_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load_s),
      .tick  (bus.frame_tick),
      .value (timer_val_s),
      .done  (timer_done_s)
   );

   // State, registered outputs and the pending-hit latch (a new hit beats the clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         hit_pend_r  <= 1'b0;
         hitbox_r    <= 1'b0;
         busy_r      <= 1'b0;
         step_fwd_r  <= 1'b0;
         step_back_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         hit_pend_r  <= bus.hit_in | (hit_pend_r & ~bus.frame_tick);
         hitbox_r    <= is_hitbox(state_nxt_s);
         busy_r      <= is_timed(state_nxt_s);
         step_fwd_r  <= bus.frame_tick & (state_nxt_s == ST_WALK);
         step_back_r <= bus.frame_tick & (state_nxt_s == ST_WALKBACK);
      end
   end

   assign bus.state         = state_r;
   assign bus.hitbox_active = hitbox_r;
   assign bus.busy          = busy_r;
   assign bus.step_fwd      = step_fwd_r;
   assign bus.step_back     = step_back_r;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Self-checking bench for sprite_anim_ctrl: directed animation scenarios plus
// randomized controls, all compared against a frame-level behavioural model.
module tb_sprite_anim_ctrl;

   localparam int AS = 6;
   localparam int AE = 4;
   localparam int AP = 6;
   localparam int HF = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cnt_f  = 0;
   int   cnt_b  = 0;

   // model state: animation state, ticks remaining in it, pending hit, step pulses
   int   m_st   = 0;
   int   m_left = 0;
   bit   m_pend = 1'b0;
   bit   m_sf   = 1'b0;
   bit   m_sb   = 1'b0;

   sprite_anim_ctrl_if bus();

   sprite_anim_ctrl #(
      .ATT_START_FR (AS),
      .ATT_END_FR   (AE),
      .ATT_PULL_FR  (AP),
      .HIT_FR       (HF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int s);
      case (s)
         3, 6:    return AS;
         4, 7:    return AE;
         5, 8:    return AP;
         9:       return HF;
         default: return 0;
      endcase
   endfunction

   function automatic int next_of(input int s);
      case (s)
         3:       return 4;
         4:       return 5;
         6:       return 7;
         7:       return 8;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_left = 0; m_pend = 1'b0; m_sf = 1'b0; m_sb = 1'b0;
   endtask

   task automatic model_step();
      bit old_pend;
      bit fwd;
      bit back;
      if (rst) begin
         model_reset();
         return;
      end
      old_pend = m_pend;
      m_sf = 1'b0;
      m_sb = 1'b0;
      if (bus.frame_tick) begin
         fwd  = bus.facing ? bus.btn_left  : bus.btn_right;
         back = bus.facing ? bus.btn_right : bus.btn_left;
         if (old_pend) begin
            if (m_st != 10) begin
               m_st = 9; m_left = HF;
            end
         end else if (m_st >= 3 && m_st <= 9) begin
            m_left--;
            if (m_left == 0) begin
               m_st = next_of(m_st);
               m_left = dur(m_st);
            end
         end else if (bus.btn_attack) begin m_st = 3; m_left = AS; end
         else if (bus.btn_dir)        begin m_st = 6; m_left = AS; end
         else if (bus.btn_block)      m_st = 10;
         else if (fwd && !back)       m_st = 1;
         else if (back && !fwd)       m_st = 2;
         else                         m_st = 0;
         m_sf = (m_st == 1);
         m_sb = (m_st == 2);
      end
      m_pend = bus.hit_in | (old_pend & !bus.frame_tick);
   endtask

   // one clock: advance the model with the inputs seen at the edge, then compare
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("state",  bus.state,         m_st);
      chk("hitbox", bus.hitbox_active, (m_st == 4 || m_st == 7));
      chk("busy",   bus.busy,          (m_st >= 3 && m_st <= 9));
      chk("step_fwd",  bus.step_fwd,   m_sf);
      chk("step_back", bus.step_back,  m_sb);
      if (bus.step_fwd)  cnt_f++;
      if (bus.step_back) cnt_b++;
      @(negedge clk);
   endtask

   // one video frame: a tick cycle then three quiet cycles, optional hit pulses
   task automatic frame(input bit hit_tick, input bit hit_mid);
      bus.frame_tick = 1'b1; bus.hit_in = hit_tick;
      cycle();
      bus.frame_tick = 1'b0; bus.hit_in = hit_mid;
      cycle();
      bus.hit_in = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
   endtask

   task automatic release_all();
      bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_attack = 1'b0;
      bus.btn_dir = 1'b0; bus.btn_block = 1'b0;
   endtask

   initial begin
      bus.frame_tick = 1'b0; bus.facing = 1'b0; bus.hit_in = 1'b0;
      release_all();
      #1;
      chk("reset_state",  bus.state, 4'd0);
      chk("reset_busy",   bus.busy, 1'b0);
      chk("reset_hitbox", bus.hitbox_active, 1'b0);
      cycle(); cycle();
      rst = 1'b0;
      cycle(); cycle();

      // attack sequence 3(6) -> 4(4) -> 5(6) -> 0
      bus.btn_attack = 1'b1; frame(1'b0, 1'b0); release_all();
      chk("att_t1", bus.state, 4'd3);
      frames(5);  chk("att_t6", bus.state, 4'd3);
      frames(1);  chk("att_t7", bus.state, 4'd4); chk("att_t7_hb", bus.hitbox_active, 1'b1);
      frames(3);  chk("att_t10", bus.state, 4'd4);
      frames(1);  chk("att_t11", bus.state, 4'd5); chk("att_t11_hb", bus.hitbox_active, 1'b0);
      frames(5);  chk("att_t16", bus.state, 4'd5);
      frames(1);  chk("att_t17", bus.state, 4'd0); chk("att_t17_busy", bus.busy, 1'b0);
      frames(1);  chk("att_idle", bus.state, 4'd0);

      // hit during attend -> stun for HIT_FR ticks
      bus.btn_attack = 1'b1; frame(1'b0, 1'b0); release_all();
      frames(6);  chk("hit_pre", bus.state, 4'd4);
      frame(1'b0, 1'b1); chk("hit_latched", bus.state, 4'd4);
      frames(1);  chk("hit_enter", bus.state, 4'd9); chk("hit_hb", bus.hitbox_active, 1'b0);
      frames(11); chk("hit_t11", bus.state, 4'd9);
      frames(1);  chk("hit_done", bus.state, 4'd0);

      // block absorbs a hit
      bus.btn_block = 1'b1; frame(1'b0, 1'b0); chk("blk_enter", bus.state, 4'd10);
      frame(1'b0, 1'b1); chk("blk_hit", bus.state, 4'd10);
      frames(1);  chk("blk_absorb", bus.state, 4'd10);
      release_all(); frames(1); chk("blk_release", bus.state, 4'd0);

      // facing left: btn_left is forward
      bus.facing = 1'b1; bus.btn_left = 1'b1; cnt_f = 0; cnt_b = 0;
      frames(3);
      chk("walk_state", bus.state, 4'd1);
      chk("walk_fwd_cnt", cnt_f, 3);
      chk("walk_back_cnt", cnt_b, 0);
      bus.btn_right = 1'b1; frames(1); chk("walk_both", bus.state, 4'd0);
      release_all(); bus.facing = 1'b0;

      // attack beats dir; dir alone runs 6,7,8
      bus.btn_attack = 1'b1; bus.btn_dir = 1'b1; frame(1'b0, 1'b0); release_all();
      chk("prio_att", bus.state, 4'd3);
      frames(16); chk("prio_done", bus.state, 4'd0);
      bus.btn_dir = 1'b1; frame(1'b0, 1'b0); release_all();
      chk("dir_t1", bus.state, 4'd6);
      frames(6);  chk("dir_t7", bus.state, 4'd7); chk("dir_hb", bus.hitbox_active, 1'b1);
      frames(3);  chk("dir_t10", bus.state, 4'd7);
      frames(1);  chk("dir_t11", bus.state, 4'd8);
      frames(5);  chk("dir_t16", bus.state, 4'd8);
      frames(1);  chk("dir_done", bus.state, 4'd0);

      // asynchronous reset in dirattend
      bus.btn_dir = 1'b1; frame(1'b0, 1'b0); release_all();
      frames(6);  chk("rst_pre", bus.state, 4'd7);
      rst = 1'b1;
      #1;
      chk("rst_async_state", bus.state, 4'd0);
      chk("rst_async_hb", bus.hitbox_active, 1'b0);
      chk("rst_async_busy", bus.busy, 1'b0);
      model_reset();
      cycle(); cycle();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      chk("rst_after", bus.state, 4'd0);

      // randomized controls and hits
      for (int f = 0; f < 300; f++) begin
         bus.btn_attack = ($urandom_range(9) == 0);
         bus.btn_dir    = ($urandom_range(9) == 0);
         bus.btn_block  = ($urandom_range(4) == 0);
         bus.btn_left   = $urandom_range(1);
         bus.btn_right  = $urandom_range(1);
         if ($urandom_range(19) == 0) bus.facing = ~bus.facing;
         frame(($urandom_range(24) == 0), ($urandom_range(11) == 0));
      end
      release_all();
      frames(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
